multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 opcode  in  7  instruction bits [6:0] from the instruction register.
REQ-005 funct3  in  3  instruction bits [14:12].
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 zero, lt  in  1 each  ALU zero and signed-less-than flags.
REQ-008 pcWrite, irWrite, adrSrc, memWrite, regWrite  out  1 each  datapath enables and selects.
REQ-009 resultSrc  out  2  00 aluOut, 01 readData, 10 aluResult, 11 immExt.
REQ-010 aluSrcA  out  2  00 PC, 01 oldPC, 10 rs1; aluSrcB  out  2  00 rs2, 01 immExt, 10 constant 4.
REQ-011 aluControl  out  3; immSrc  out  3; halted  out  1.

Function
REQ-012 Moore FSM with states START, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, JALR_LINK, LUI, HALT; all outputs combinational from state, opcode, funct3, funct7b5, zero and lt.
REQ-013 START: all enables 0, always goes to FETCH.
REQ-014 FETCH: adrSrc=0, irWrite=1, aluSrcA=PC, aluSrcB=4, add, resultSrc=10, pcWrite=1; goes to DECODE.
REQ-015 DECODE: aluSrcA=oldPC, aluSrcB=imm, add (target into aluOut); next state by opcode: 0000011/0100011 MEM_ADR, 0110011 EXEC_R, 0010011 EXEC_I, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, otherwise illegal.
REQ-016 MEM_ADR: rs1+imm; next MEM_RD for load, MEM_WR for store. MEM_RD: adrSrc=1, then MEM_WB. MEM_WB: resultSrc=01, regWrite=1, then FETCH. MEM_WR: adrSrc=1, memWrite=1, then FETCH.
REQ-017 EXEC_R (rs1,rs2) and EXEC_I (rs1,imm) go to ALU_WB; ALU_WB: resultSrc=00, regWrite=1, then FETCH.
REQ-018 ALU decode: add 000, sub 001, and 010, or 011, xor 100, slt 101; funct3 000 gives sub only when R-type and funct7b5=1.
REQ-019 BRANCH: rs1 vs rs2; funct3[2]=0 uses sub and zero, funct3[2]=1 uses slt and lt; pcWrite=(flag XOR funct3[0]), resultSrc=00; then FETCH.
REQ-020 JAL: aluSrcA=oldPC, aluSrcB=4, add, resultSrc=00, pcWrite=1, then ALU_WB.
REQ-021 JALR: rs1+imm into aluOut, no writes; JALR_LINK behaves as JAL; then ALU_WB (rd written after rs1 consumed, so rd=rs1 is safe).
REQ-022 LUI: resultSrc=11, regWrite=1, then FETCH.
REQ-023 immSrc from opcode in every state: I 000, S 001, B 010, J 011, U 100; unlisted opcodes give 000.
REQ-024 At most one of memWrite and regWrite is asserted in any cycle.

Reset
REQ-025 While rst=0: state is START, all enables 0, halted=0, all selects 00, aluControl=000, and all of this takes effect immediately, independent of clk.
REQ-026 Reset mid-instruction abandons the instruction with no further write.

Configuration
REQ-027 Macro ILLEGAL_TRAP_EN: when defined, an illegal opcode in DECODE goes to HALT; HALT holds all enables at 0 and halted=1 until reset. When undefined, an illegal opcode returns to FETCH as a NOP, and HALT is unreachable.

Structure
REQ-028 A shared package holds the state enum, the aluControl, immSrc, resultSrc, aluSrcA and aluSrcB encodings, and the opcode constants.
REQ-029 One sub-module, alu_decoder, maps state-class, funct3 and funct7b5 to aluControl.

Verification
REQ-030 Release reset, instruction 0x00500093 (addi) -> states FETCH, DECODE, EXEC_I, ALU_WB; aluControl=000 in EXEC_I; regWrite=1 only in cycle 4.
REQ-031 beq with zero=1 -> pcWrite=1 in BRANCH; bne with zero=1 -> pcWrite=0; blt with lt=1 -> pcWrite=1, aluControl=101.
REQ-032 sw 0x0020A023 -> MEM_WR asserts memWrite=1 and adrSrc=1 for exactly one cycle; regWrite stays 0 throughout.
REQ-033 jalr 0x000080E7 -> states FETCH, DECODE, JALR, JALR_LINK, ALU_WB; pcWrite=1 only in FETCH and JALR_LINK.
REQ-034 Instruction 0x00000000 -> with ILLEGAL_TRAP_EN, HALT with halted=1 held for 10 or more cycles; without it, the next state is FETCH.
REQ-035 rst=0 asserted mid-cycle in MEM_WR -> memWrite drops before the next clk edge; after release, START then FETCH.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V controller:
// FSM states, ALU/immediate/mux select codes and opcode constants.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    START,
    FETCH,
    DECODE,
    MEM_ADR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    BRANCH,
    JAL,
    JALR,
    JALR_LINK,
    LUI,
    HALT
  } state_t;

  // Which rule set the ALU decoder applies in the current state
  typedef enum logic [1:0] {
    ALU_CLS_ADD,
    ALU_CLS_R,
    ALU_CLS_I,
    ALU_CLS_BRANCH
  } alu_class_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Immediate format depends only on the opcode; anything unlisted reads as I-type
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU decoder: maps the state class, funct3 and funct7b5 to an aluControl code.
module alu_decoder
  import multi_cycle_controller_pkg::*;
(
  input  logic [1:0] i_alu_class,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  alu_class_t w_class;
  logic       w_is_sub;

  assign w_class  = alu_class_t'(i_alu_class);
  // Immediate forms never subtract, so bit 30 of an addi immediate is ignored
  assign w_is_sub = (w_class == ALU_CLS_R) && i_funct7b5;

  always_comb begin
    o_alu_control = ALU_ADD;
    case (w_class)
      ALU_CLS_R, ALU_CLS_I: begin
        case (i_funct3)
          3'b000:  o_alu_control = w_is_sub ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b100:  o_alu_control = ALU_XOR;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      ALU_CLS_BRANCH: o_alu_control = i_funct3[2] ? ALU_SLT : ALU_SUB;
      default:        o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore-style multi-cycle RISC-V control FSM. Define ILLEGAL_TRAP_EN to make an
// illegal opcode park the controller in HALT; otherwise it executes as a NOP.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic [2:0] immSrc,
  output logic       halted
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = HALT;
`else
  localparam state_t ILLEGAL_NEXT = FETCH;
`endif

  state_t     r_state;
  state_t     w_next_state;
  alu_class_t w_alu_class;
  logic [2:0] w_dec_alu_control;
  logic       w_branch_flag;
  logic       w_branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= START;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      START:  w_next_state = FETCH;
      FETCH:  w_next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next_state = MEM_ADR;
          OP_RTYPE:          w_next_state = EXEC_R;
          OP_ITYPE:          w_next_state = EXEC_I;
          OP_BRANCH:         w_next_state = BRANCH;
          OP_JAL:            w_next_state = JAL;
          OP_JALR:           w_next_state = JALR;
          OP_LUI:            w_next_state = LUI;
          default:           w_next_state = ILLEGAL_NEXT;
        endcase
      end
      MEM_ADR:   w_next_state = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD:    w_next_state = MEM_WB;
      MEM_WB:    w_next_state = FETCH;
      MEM_WR:    w_next_state = FETCH;
      EXEC_R:    w_next_state = ALU_WB;
      EXEC_I:    w_next_state = ALU_WB;
      ALU_WB:    w_next_state = FETCH;
      BRANCH:    w_next_state = FETCH;
      JAL:       w_next_state = ALU_WB;
      JALR:      w_next_state = JALR_LINK;
      JALR_LINK: w_next_state = ALU_WB;
      LUI:       w_next_state = FETCH;
      HALT:      w_next_state = HALT;
      default:   w_next_state = START;
    endcase
  end

  always_comb begin
    w_alu_class = ALU_CLS_ADD;
    case (r_state)
      EXEC_R:  w_alu_class = ALU_CLS_R;
      EXEC_I:  w_alu_class = ALU_CLS_I;
      BRANCH:  w_alu_class = ALU_CLS_BRANCH;
      default: w_alu_class = ALU_CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_class   (w_alu_class),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .o_alu_control (w_dec_alu_control)
  );

  // funct3[2] picks signed compare vs equality; funct3[0] inverts the sense
  assign w_branch_flag  = funct3[2] ? lt : zero;
  assign w_branch_taken = w_branch_flag ^ funct3[0];

  // rst gates every output so reset silences the datapath without waiting for clk
  always_comb begin
    pcWrite    = 1'b0;
    irWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    halted     = 1'b0;
    resultSrc  = RES_ALUOUT;
    aluSrcA    = SRCA_PC;
    aluSrcB    = SRCB_RS2;
    aluControl = ALU_ADD;
    immSrc     = IMM_I;
    if (rst) begin
      immSrc     = imm_src_of(opcode);
      aluControl = w_dec_alu_control;
      case (r_state)
        FETCH: begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          aluSrcA   = SRCA_PC;
          aluSrcB   = SRCB_FOUR;
          resultSrc = RES_ALURESULT;
        end
        DECODE: begin
          aluSrcA = SRCA_OLDPC;
          aluSrcB = SRCB_IMM;
        end
        MEM_ADR, EXEC_I, JALR: begin
          aluSrcA = SRCA_RS1;
          aluSrcB = SRCB_IMM;
        end
        MEM_RD: adrSrc = 1'b1;
        MEM_WB: begin
          resultSrc = RES_READDATA;
          regWrite  = 1'b1;
        end
        MEM_WR: begin
          adrSrc   = 1'b1;
          memWrite = 1'b1;
        end
        EXEC_R: begin
          aluSrcA = SRCA_RS1;
          aluSrcB = SRCB_RS2;
        end
        ALU_WB: begin
          resultSrc = RES_ALUOUT;
          regWrite  = 1'b1;
        end
        BRANCH: begin
          aluSrcA   = SRCA_RS1;
          aluSrcB   = SRCB_RS2;
          resultSrc = RES_ALUOUT;
          pcWrite   = w_branch_taken;
        end
        JAL, JALR_LINK: begin
          aluSrcA   = SRCA_OLDPC;
          aluSrcB   = SRCB_FOUR;
          resultSrc = RES_ALUOUT;
          pcWrite   = 1'b1;
        end
        LUI: begin
          resultSrc = RES_IMMEXT;
          regWrite  = 1'b1;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: directed vector table, reset/illegal corner
// sequences and random instructions against a per-instruction micro-sequence model.
module tb_multi_cycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       adr;
    logic       memw;
    logic       regw;
    logic       hlt;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [2:0] imm;
  } out_t;

  typedef out_t out_q_t[$];

  typedef struct {
    logic [31:0] instr;
    logic        z;
    logic        l;
    logic [2:0]  c3_alu;
    logic        c3_pcw;
    int          regw_cyc;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic       pcWrite, irWrite, adrSrc, memWrite, regWrite, halted;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  logic [2:0] aluControl, immSrc;
  out_t       act;

  int n_vec  = 0;
  int n_miss = 0;

  multi_cycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .lt         (lt),
    .pcWrite    (pcWrite),
    .irWrite    (irWrite),
    .adrSrc     (adrSrc),
    .memWrite   (memWrite),
    .regWrite   (regWrite),
    .resultSrc  (resultSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .aluControl (aluControl),
    .immSrc     (immSrc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign act = {pcWrite, irWrite, adrSrc, memWrite, regWrite, halted,
                resultSrc, aluSrcA, aluSrcB, aluControl, immSrc};

  // ---------------- reference model ----------------
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37};
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    case (op)
      7'h23:   return 3'd1;
      7'h63:   return 3'd2;
      7'h6F:   return 3'd3;
      7'h37:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // add 0, sub 1, and 2, or 3, xor 4, slt 5
  function automatic logic [2:0] ref_alu(input logic rtype, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (rtype && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic out_t blank(input logic [6:0] op);
    out_t o;
    o     = '0;
    o.imm = ref_imm(op);
    return o;
  endfunction

  function automatic out_t alu_step(input logic [6:0] op, input logic [1:0] a, input logic [1:0] b,
                                    input logic [2:0] c);
    out_t o;
    o      = blank(op);
    o.srca = a;
    o.srcb = b;
    o.aluc = c;
    return o;
  endfunction

  // Full per-cycle output sequence of one instruction, starting at its fetch cycle
  function automatic out_q_t build_seq(input logic [31:0] ins, input logic z, input logic l);
    out_q_t     q;
    out_t       o;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[30];
    o = alu_step(op, 2'd0, 2'd2, 3'd0); o.pcw = 1'b1; o.irw = 1'b1; o.res = 2'd2;
    q.push_back(o);
    q.push_back(alu_step(op, 2'd1, 2'd1, 3'd0));
    o = blank(op); o.regw = 1'b1;
    case (op)
      7'h03: begin
        q.push_back(alu_step(op, 2'd2, 2'd1, 3'd0));
        o = blank(op); o.adr = 1'b1; q.push_back(o);
        o = blank(op); o.res = 2'd1; o.regw = 1'b1; q.push_back(o);
      end
      7'h23: begin
        q.push_back(alu_step(op, 2'd2, 2'd1, 3'd0));
        o = blank(op); o.adr = 1'b1; o.memw = 1'b1; q.push_back(o);
      end
      7'h33: begin
        q.push_back(alu_step(op, 2'd2, 2'd0, ref_alu(1'b1, f3, f7)));
        q.push_back(o);
      end
      7'h13: begin
        q.push_back(alu_step(op, 2'd2, 2'd1, ref_alu(1'b0, f3, f7)));
        q.push_back(o);
      end
      7'h63: begin
        o = alu_step(op, 2'd2, 2'd0, f3[2] ? 3'd5 : 3'd1);
        o.pcw = (f3[2] ? l : z) ^ f3[0];
        q.push_back(o);
      end
      7'h6F: begin
        o = alu_step(op, 2'd1, 2'd2, 3'd0); o.pcw = 1'b1; q.push_back(o);
        o = blank(op); o.regw = 1'b1; q.push_back(o);
      end
      7'h67: begin
        q.push_back(alu_step(op, 2'd2, 2'd1, 3'd0));
        o = alu_step(op, 2'd1, 2'd2, 3'd0); o.pcw = 1'b1; q.push_back(o);
        o = blank(op); o.regw = 1'b1; q.push_back(o);
      end
      7'h37: begin
        o = blank(op); o.res = 2'd3; o.regw = 1'b1; q.push_back(o);
      end
      default: ;
    endcase
    return q;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  task automatic check_val(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic z, input logic l);
    opcode   = ins[6:0];
    funct3   = ins[14:12];
    funct7b5 = ins[30];
    zero     = z;
    lt       = l;
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after the last cycle
  task automatic run_instr(input logic [31:0] ins, input logic z, input logic l, input string tag,
                           output logic [2:0] c3_alu, output logic c3_pcw, output int regw_cyc);
    out_q_t q;
    q = build_seq(ins, z, l);
    drive(ins, z, l);
    c3_alu   = 3'd0;
    c3_pcw   = 1'b0;
    regw_cyc = 0;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, k + 1), q[k]);
      if (k == 2) begin
        c3_alu = aluControl;
        c3_pcw = pcWrite;
      end
      if (regWrite && regw_cyc == 0) regw_cyc = k + 1;
      @(posedge clk);
      #1;
    end
    $display("txn %s instr=%08h zero=%0b lt=%0b cycles=%0d", tag, ins, z, l, q.size());
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    check("reset_async", '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("start_after_reset", blank(opcode));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  vec_t        tbl[19];
  logic [2:0]  g_alu;
  logic        g_pcw;
  int          g_regw;
  out_q_t      sq;
  logic [6:0]  legal_ops[8];

  initial begin
    tbl[0]  = '{32'h00500093, 1'b0, 1'b0, 3'd0, 1'b0, 4, "addi"};
    tbl[1]  = '{32'h00208063, 1'b1, 1'b0, 3'd1, 1'b1, 0, "beq_z1"};
    tbl[2]  = '{32'h00209063, 1'b1, 1'b0, 3'd1, 1'b0, 0, "bne_z1"};
    tbl[3]  = '{32'h00209063, 1'b0, 1'b0, 3'd1, 1'b1, 0, "bne_z0"};
    tbl[4]  = '{32'h0020C063, 1'b0, 1'b1, 3'd5, 1'b1, 0, "blt_lt1"};
    tbl[5]  = '{32'h0020D063, 1'b0, 1'b1, 3'd5, 1'b0, 0, "bge_lt1"};
    tbl[6]  = '{32'h0020A023, 1'b0, 1'b0, 3'd0, 1'b0, 0, "sw"};
    tbl[7]  = '{32'h0000A083, 1'b0, 1'b0, 3'd0, 1'b0, 5, "lw"};
    tbl[8]  = '{32'h002081B3, 1'b0, 1'b0, 3'd0, 1'b0, 4, "add"};
    tbl[9]  = '{32'h402081B3, 1'b0, 1'b0, 3'd1, 1'b0, 4, "sub"};
    tbl[10] = '{32'h0020F1B3, 1'b0, 1'b0, 3'd2, 1'b0, 4, "and"};
    tbl[11] = '{32'h0020E1B3, 1'b0, 1'b0, 3'd3, 1'b0, 4, "or"};
    tbl[12] = '{32'h0020C1B3, 1'b0, 1'b0, 3'd4, 1'b0, 4, "xor"};
    tbl[13] = '{32'h0020A1B3, 1'b0, 1'b0, 3'd5, 1'b0, 4, "slt"};
    tbl[14] = '{32'hC0000093, 1'b0, 1'b0, 3'd0, 1'b0, 4, "addi_b30"};
    tbl[15] = '{32'h000000EF, 1'b0, 1'b0, 3'd0, 1'b1, 4, "jal"};
    tbl[16] = '{32'h000080E7, 1'b0, 1'b0, 3'd0, 1'b0, 5, "jalr"};
    tbl[17] = '{32'h000010B7, 1'b0, 1'b0, 3'd0, 1'b0, 3, "lui"};
    tbl[18] = '{32'h0050A093, 1'b0, 1'b0, 3'd5, 1'b0, 4, "slti"};
    legal_ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37};

    // Reset holds everything at zero even with a store opcode on the inputs
    rst = 1'b0;
    drive(32'h0020A023, 1'b1, 1'b1);
    #2;
    check("reset_idle", '0);
    @(negedge clk);
    check("reset_held_edge", '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("start_state", blank(opcode));
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].instr, tbl[i].z, tbl[i].l, tbl[i].name, g_alu, g_pcw, g_regw);
      check_val({tbl[i].name, "_c3_alu"}, g_alu, tbl[i].c3_alu);
      check_val({tbl[i].name, "_c3_pcw"}, g_pcw, tbl[i].c3_pcw);
      check_val({tbl[i].name, "_regw_cycle"}, g_regw, tbl[i].regw_cyc);
    end

    // Illegal all-zero instruction
    run_instr(32'h00000000, 1'b0, 1'b0, "illegal", g_alu, g_pcw, g_regw);
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 12; k++) begin
      out_t h;
      h     = blank(7'h00);
      h.hlt = 1'b1;
      @(negedge clk);
      check($sformatf("halt_c%0d", k), h);
      @(posedge clk);
      #1;
    end
    reset_pulse();
`else
    @(negedge clk);
    check("illegal_nop_fetch", build_seq(32'h00500093, 1'b0, 1'b0)[0]);
    @(posedge clk);
    #1;
    // Having consumed that fetch cycle, finish the addi it started
    sq = build_seq(32'h00500093, 1'b0, 1'b0);
    drive(32'h00500093, 1'b0, 1'b0);
    for (int k = 1; k < sq.size(); k++) begin
      @(negedge clk);
      check($sformatf("post_nop_c%0d", k + 1), sq[k]);
      @(posedge clk);
      #1;
    end
`endif

    // Reset asserted in the middle of MEM_WR must kill memWrite at once
    sq = build_seq(32'h0020A023, 1'b0, 1'b0);
    drive(32'h0020A023, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("sw_rst_c%0d", k + 1), sq[k]);
      @(posedge clk);
      #1;
    end
    #1;
    check("sw_memwr_before_rst", sq[3]);
    #1;
    rst = 1'b0;
    #1;
    check("memwr_drop_async", '0);
    @(posedge clk);
    #1;
    check("memwr_reset_held", '0);
    rst = 1'b1;
    @(negedge clk);
    check("start_after_midrst", blank(opcode));
    @(posedge clk);
    #1;
    run_instr(32'h00500093, 1'b0, 1'b0, "addi_after_rst", g_alu, g_pcw, g_regw);

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ins;
      logic [6:0]  op;
      int          pick;
      ins = $urandom;
`ifdef ILLEGAL_TRAP_EN
      pick = $urandom_range(0, 7);
`else
      pick = $urandom_range(0, 8);
`endif
      if (pick < 8) begin
        op = legal_ops[pick];
      end else begin
        op = 7'($urandom_range(0, 127));
        while (is_legal(op)) op = 7'($urandom_range(0, 127));
      end
      ins[6:0] = op;
      run_instr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", n), g_alu, g_pcw, g_regw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
